// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ISA definitions for the fetch unit and the controller FSM.
// Holds opcode/opext constants, instruction-type codes, condition codes and
// small helpers classifying immediate opcodes.
package cpu_pkg;

    // Primary opcodes, ir[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_EXT   = 4'b0100;  // LOAD / STOR / JCOND group
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_SUBCI = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_MULI  = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Opcode extensions within OP_EXT, ir[7:4]
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    typedef enum logic [1:0] {
        ITYPE_ALU    = 2'b00,
        ITYPE_STORE  = 2'b01,
        ITYPE_LOAD   = 2'b10,
        ITYPE_BRANCH = 2'b11
    } instr_type_e;

    // Condition codes
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_LT = 4'b0100;
    localparam logic [3:0] CC_GE = 4'b0101;
    localparam logic [3:0] CC_LE = 4'b0110;
    localparam logic [3:0] CC_GT = 4'b0111;
    localparam logic [3:0] CC_UC = 4'b1110;

    // Arithmetic immediates: 8-bit field is sign-extended.
    function automatic logic is_arith_imm(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_ADDUI) || (op == OP_ADDCI) ||
               (op == OP_SUBI) || (op == OP_SUBCI) || (op == OP_CMPI)  ||
               (op == OP_MULI);
    endfunction

    // Logical immediates: 8-bit field is zero-extended.
    function automatic logic is_logic_imm(input logic [3:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) ||
               (op == OP_MOVI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a 4-bit branch condition against the PSR flags.
// Ports: cond[3:0] condition code, z/n/c flags in, taken out (combinational).
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       z,
    input  logic       n,
    input  logic       c,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = z;
            CC_NE:   taken = !z;
            CC_CS:   taken = c;
            CC_CC:   taken = !c;
            CC_LT:   taken = n;
            CC_GE:   taken = !n;
            CC_LE:   taken = n | z;
            CC_GT:   taken = !n & !z;
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, instruction register and decode.
// Ports: clk, reset (async, active-high); pc_en / ir_en strobes from the
// controller; mem_rdata instruction word; flag_z/n/c PSR flags; jump_target
// (Rsrc for JCOND). Outputs pc (fetch address), ir, decoded instr_type,
// rdest, rsrc, imm, imm_sel, and registered branch_taken.
module instr_fetch_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic        ir_en,
    input  logic [15:0] mem_rdata,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_c,
    input  logic [15:0] jump_target,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [1:0]  instr_type,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic [15:0] imm,
    output logic        imm_sel,
    output logic        branch_taken
);

    logic [3:0]  opcode;
    logic [3:0]  opext;
    logic        is_bcond;
    logic        is_jcond;
    logic [3:0]  cond;
    logic        cond_true;
    logic        taken;
    logic [15:0] pc_next;
    instr_type_e itype;

    assign opcode   = ir[15:12];
    assign opext    = ir[7:4];
    assign is_bcond = (opcode == OP_BCOND);
    assign is_jcond = (opcode == OP_EXT) && (opext == EXT_JCOND);

    // BCOND carries its condition in the rdest slot; JCOND in the rsrc slot.
    assign cond = is_bcond ? ir[11:8] : ir[3:0];

    cond_eval u_cond_eval (
        .cond  (cond),
        .z     (flag_z),
        .n     (flag_n),
        .c     (flag_c),
        .taken (cond_true)
    );

    assign taken = (is_bcond | is_jcond) & cond_true;

    always_comb begin
        pc_next = pc + 16'd1;
        if (is_bcond && cond_true)
            pc_next = pc + {{8{ir[7]}}, ir[7:0]};
        else if (is_jcond && cond_true)
            pc_next = jump_target;
    end

    // Decode is purely from ir so it is stable for the whole post-fetch cycle.
    always_comb begin
        itype = ITYPE_ALU;
        if (is_bcond || is_jcond)
            itype = ITYPE_BRANCH;
        else if (opcode == OP_EXT && opext == EXT_LOAD)
            itype = ITYPE_LOAD;
        else if (opcode == OP_EXT && opext == EXT_STOR)
            itype = ITYPE_STORE;
    end

    assign instr_type = itype;
    assign rdest      = ir[11:8];
    assign rsrc       = ir[3:0];
    assign imm_sel    = is_arith_imm(opcode) | is_logic_imm(opcode);
    assign imm        = is_arith_imm(opcode) ? {{8{ir[7]}}, ir[7:0]}
                                             : {8'h00, ir[7:0]};

    // pc uses the pre-edge ir, so a simultaneous ir_en does not affect it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= '0;
            ir           <= '0;
            branch_taken <= 1'b0;
        end else begin
            if (pc_en)
                pc <= pc_next;
            if (ir_en)
                ir <= mem_rdata;
            branch_taken <= pc_en & taken;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_en;
    logic        ir_en;
    logic [15:0] mem_rdata;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [1:0]  instr_type;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        imm_sel;
    logic        branch_taken;

    int passed;
    int failed;
    int total;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .pc_en        (pc_en),
        .ir_en        (ir_en),
        .mem_rdata    (mem_rdata),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_c       (flag_c),
        .jump_target  (jump_target),
        .pc           (pc),
        .ir           (ir),
        .instr_type   (instr_type),
        .rdest        (rdest),
        .rsrc         (rsrc),
        .imm          (imm),
        .imm_sel      (imm_sel),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] w);
        mem_rdata = w;
        ir_en = 1'b1;
        tick();
        ir_en = 1'b0;
    endtask

    task automatic step_pc();
        pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
    endtask

    // Place pc at an arbitrary address via JCOND UC.
    task automatic set_pc(input logic [15:0] a);
        load_ir(16'h40CE);
        jump_target = a;
        step_pc();
    endtask

    // {cond[3:0], z, n, c, expected taken}
    localparam logic [7:0] COND_TAB [8] = '{
        {4'h1, 1'b0, 1'b0, 1'b0, 1'b1},   // NE, Z=0 -> taken
        {4'h2, 1'b0, 1'b0, 1'b0, 1'b0},   // CS, C=0 -> not
        {4'h3, 1'b0, 1'b0, 1'b0, 1'b1},   // CC, C=0 -> taken
        {4'h4, 1'b0, 1'b1, 1'b0, 1'b1},   // LT, N=1 -> taken
        {4'h5, 1'b0, 1'b1, 1'b0, 1'b0},   // GE, N=1 -> not
        {4'h6, 1'b1, 1'b0, 1'b0, 1'b1},   // LE, Z=1 -> taken
        {4'h7, 1'b1, 1'b0, 1'b0, 1'b0},   // GT, Z=1 -> not
        {4'hF, 1'b1, 1'b1, 1'b1, 1'b0}    // reserved code -> not
    };

    initial begin
        logic [7:0]  e;
        logic [15:0] exp_pc;
        passed = 0;
        failed = 0;
        total  = 0;

        // Reset with both strobes held high
        reset       = 1'b1;
        pc_en       = 1'b1;
        ir_en       = 1'b1;
        mem_rdata   = 16'hC0FC;
        flag_z      = 1'b1;
        flag_n      = 1'b0;
        flag_c      = 1'b0;
        jump_target = 16'h5555;
        #1;
        check("rst_pc_async", pc, 16'h0000);
        check("rst_ir_async", ir, 16'h0000);
        tick();
        tick();
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_itype", {14'd0, instr_type}, 16'd0);
        check("rst_bt", {15'd0, branch_taken}, 16'd0);
        pc_en = 1'b0;
        ir_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_hold_pc", pc, 16'h0000);

        // LOAD decode and sequential advance
        set_pc(16'h0010);
        load_ir(16'h4105);
        check("load_ir", ir, 16'h4105);
        check("load_itype", {14'd0, instr_type}, 16'd2);
        check("load_rdest", {12'd0, rdest}, 16'd1);
        check("load_rsrc", {12'd0, rsrc}, 16'd5);
        check("load_immsel", {15'd0, imm_sel}, 16'd0);
        step_pc();
        check("load_pc", pc, 16'h0011);
        check("load_bt", {15'd0, branch_taken}, 16'd0);

        // STORE decode
        load_ir(16'h4243);
        check("store_itype", {14'd0, instr_type}, 16'd1);

        // BCOND EQ taken, disp -4
        set_pc(16'h0020);
        load_ir(16'hC0FC);
        flag_z = 1'b1;
        check("bcond_itype", {14'd0, instr_type}, 16'd3);
        step_pc();
        check("bcond_t_pc", pc, 16'h001C);
        check("bcond_t_bt", {15'd0, branch_taken}, 16'd1);
        tick();
        check("hold_pc", pc, 16'h001C);
        check("hold_ir", ir, 16'hC0FC);
        check("bt_one_cycle", {15'd0, branch_taken}, 16'd0);

        // BCOND EQ not taken
        set_pc(16'h0020);
        load_ir(16'hC0FC);
        flag_z = 1'b0;
        step_pc();
        check("bcond_nt_pc", pc, 16'h0021);
        check("bcond_nt_bt", {15'd0, branch_taken}, 16'd0);

        // JCOND UC
        load_ir(16'h40CE);
        jump_target = 16'h1234;
        check("jcond_itype", {14'd0, instr_type}, 16'd3);
        check("jcond_rsrc", {12'd0, rsrc}, 16'd14);
        step_pc();
        check("jcond_pc", pc, 16'h1234);
        check("jcond_bt", {15'd0, branch_taken}, 16'd1);

        // Wrap at 0xFFFF with a logical immediate (zero-extended)
        set_pc(16'hFFFF);
        load_ir(16'h1294);
        check("andi_immsel", {15'd0, imm_sel}, 16'd1);
        check("andi_imm", imm, 16'h0094);
        check("andi_itype", {14'd0, instr_type}, 16'd0);
        step_pc();
        check("wrap_pc", pc, 16'h0000);

        // Arithmetic immediate is sign-extended
        load_ir(16'h51F0);
        check("addi_imm", imm, 16'hFFF0);
        check("addi_immsel", {15'd0, imm_sel}, 16'd1);

        // Simultaneous strobes: pc from old BCOND UC +2, ir loads new word
        set_pc(16'h0005);
        load_ir(16'hCE02);
        mem_rdata = 16'h0123;
        pc_en = 1'b1;
        ir_en = 1'b1;
        tick();
        pc_en = 1'b0;
        ir_en = 1'b0;
        check("both_pc", pc, 16'h0007);
        check("both_ir", ir, 16'h0123);
        check("both_bt", {15'd0, branch_taken}, 16'd1);
        check("both_itype", {14'd0, instr_type}, 16'd0);

        // JCOND condition table
        for (int i = 0; i < 8; i++) begin
            e = COND_TAB[i];
            set_pc(16'h0100);
            load_ir({12'h40C, e[7:4]});
            flag_z = e[3];
            flag_n = e[2];
            flag_c = e[1];
            jump_target = 16'h0200;
            exp_pc = e[0] ? 16'h0200 : 16'h0101;
            step_pc();
            check($sformatf("cond%0d_pc", i), pc, exp_pc);
            check($sformatf("cond%0d_bt", i), {15'd0, branch_taken}, {15'd0, e[0]});
        end

        // Asynchronous reset mid-operation, between clock edges
        set_pc(16'h0ABC);
        pc_en = 1'b1;
        ir_en = 1'b1;
        mem_rdata = 16'h4105;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_pc", pc, 16'h0000);
        check("midrst_ir", ir, 16'h0000);
        check("midrst_bt", {15'd0, branch_taken}, 16'd0);
        pc_en = 1'b0;
        ir_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        load_ir(16'h4105);
        check("after_rst_ir", ir, 16'h4105);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
